// File: rtl/mul_div_unit.sv
// mul_div_unit: sequential multiply/divide unit for the MIPS ALU.
// One iteration per clock. Multiply uses shift-add and divide uses restoring division.
// Signed operations work on magnitudes; the sign is applied in a final FIX cycle.
//
// Ports:
//   clockMul  rising-edge clock
//   reset     synchronous, active-high
//   start     request, sampled only while idle
//   op        00 MULTU, 01 MULT, 10 DIVU, 11 DIV
//   mult1     multiplicand / dividend
//   mult2     multiplier / divisor
//   busy      high from accept until the completion edge
//   done      one-cycle completion pulse
//   hi        product upper half / remainder
//   lo        product lower half / quotient
//   divZero   last completed op was a divide by zero
module mul_div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clockMul,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] mult1,
  input  logic [WIDTH-1:0] mult2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             divZero
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {StIdle, StRun, StFix} state_e;

  state_e                 state_q, state_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic [1:0]             op_q, op_d;
  logic [WIDTH-1:0]       a_q, a_d;
  logic [WIDTH-1:0]       b_q, b_d;
  logic                   sign_a_q, sign_a_d;
  logic                   sign_b_q, sign_b_d;
  logic [2*WIDTH-1:0]     acc_q, acc_d;
  logic [WIDTH-1:0]       hi_q, hi_d;
  logic [WIDTH-1:0]       lo_q, lo_d;
  logic                   done_q, done_d;
  logic                   div_zero_q, div_zero_d;

  // Operand magnitudes at accept time.
  logic             in_sign_a, in_sign_b;
  logic [WIDTH-1:0] abs_a, abs_b;

  // One iteration step for each mode.
  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   mul_next;
  logic [WIDTH:0]       rem_sh;
  logic [WIDTH:0]       diff;
  logic                 qbit;
  logic [2*WIDTH-1:0]   div_next;

  // Sign-corrected results for FIX.
  logic [2*WIDTH-1:0]   prod_fix;
  logic [WIDTH-1:0]     quot_fix, rem_fix, raw_a;
  logic                 neg_result;

  always_comb begin
    in_sign_a = op[0] & mult1[WIDTH-1];
    in_sign_b = op[0] & mult2[WIDTH-1];
    abs_a     = in_sign_a ? WIDTH'(0) - mult1 : mult1;
    abs_b     = in_sign_b ? WIDTH'(0) - mult2 : mult2;

    // Accumulator holds {partial product, remaining multiplier bits}; shift right each step.
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? b_q : WIDTH'(0))};
    mul_next = {mul_sum, acc_q[WIDTH-1:1]};

    // Accumulator holds {remainder, dividend/quotient}; shift left and trial-subtract.
    rem_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    diff     = rem_sh - {1'b0, b_q};
    qbit     = ~diff[WIDTH];
    div_next = {(qbit ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0]), acc_q[WIDTH-2:0], qbit};

    neg_result = op_q[0] & (sign_a_q ^ sign_b_q);
    prod_fix   = neg_result ? (2*WIDTH)'(0) - acc_q : acc_q;
    quot_fix   = neg_result ? WIDTH'(0) - acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    // Remainder follows the dividend's sign.
    rem_fix    = sign_a_q ? WIDTH'(0) - acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    raw_a      = sign_a_q ? WIDTH'(0) - a_q : a_q;
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    sign_a_d   = sign_a_q;
    sign_b_d   = sign_b_q;
    acc_d      = acc_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    done_d     = 1'b0;
    div_zero_d = div_zero_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          op_d     = op;
          a_d      = abs_a;
          b_d      = abs_b;
          sign_a_d = in_sign_a;
          sign_b_d = in_sign_b;
          acc_d    = {{WIDTH{1'b0}}, abs_a};
          cnt_d    = '0;
          // A zero divisor skips the iterations entirely.
          state_d  = (op[1] && mult2 == '0) ? StFix : StRun;
        end
      end
      StRun: begin
        acc_d = op_q[1] ? div_next : mul_next;
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == CntW'(WIDTH - 1)) begin
          state_d = StFix;
        end
      end
      StFix: begin
        done_d  = 1'b1;
        cnt_d   = '0;
        state_d = StIdle;
        if (op_q[1] && b_q == '0) begin
          hi_d       = raw_a;
          lo_d       = '1;
          div_zero_d = 1'b1;
        end else if (op_q[1]) begin
          hi_d       = rem_fix;
          lo_d       = quot_fix;
          div_zero_d = 1'b0;
        end else begin
          hi_d       = prod_fix[2*WIDTH-1:WIDTH];
          lo_d       = prod_fix[WIDTH-1:0];
          div_zero_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clockMul) begin
    if (reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      sign_a_q   <= 1'b0;
      sign_b_q   <= 1'b0;
      acc_q      <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_q       <= op_d;
      a_q        <= a_d;
      b_q        <= b_d;
      sign_a_q   <= sign_a_d;
      sign_b_q   <= sign_b_d;
      acc_q      <= acc_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      done_q     <= done_d;
      div_zero_q <= div_zero_d;
    end
  end

  assign busy    = (state_q != StIdle);
  assign done    = done_q;
  assign hi      = hi_q;
  assign lo      = lo_q;
  assign divZero = div_zero_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: a 32-bit instance for most vectors and an
// 8-bit instance for the narrow-width case. Outputs are sampled on the falling edge.
module tb_mul_div_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] mult1, mult2;
  logic        busy, done, div_zero;
  logic [31:0] hi, lo;

  logic        start8;
  logic [1:0]  op8;
  logic [7:0]  a8, b8;
  logic        busy8, done8, div_zero8;
  logic [7:0]  hi8, lo8;

  int checks = 0;
  int errors = 0;

  mul_div_unit #(.WIDTH(32)) dut (
    .clockMul (clk),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .mult1    (mult1),
    .mult2    (mult2),
    .busy     (busy),
    .done     (done),
    .hi       (hi),
    .lo       (lo),
    .divZero  (div_zero)
  );

  mul_div_unit #(.WIDTH(8)) dut8 (
    .clockMul (clk),
    .reset    (reset),
    .start    (start8),
    .op       (op8),
    .mult1    (a8),
    .mult2    (b8),
    .busy     (busy8),
    .done     (done8),
    .hi       (hi8),
    .lo       (lo8),
    .divZero  (div_zero8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive a request now; the next rising edge accepts it. Returns at the falling
  // edge after the accept edge with operands scrambled.
  task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1;
    op    = o;
    mult1 = a;
    mult2 = b;
    @(negedge clk);
    start = 1'b0;
    op    = ~o;
    mult1 = 32'hdead_beef;
    mult2 = 32'h1234_5678;
  endtask

  // Count edges after the accept edge until done is seen (bounded).
  task automatic wait_done(input int n0, output int lat, output int busy_cnt);
    lat      = n0;
    busy_cnt = 0;
    while (!done && lat < 100) begin
      if (busy) busy_cnt++;
      @(negedge clk);
      lat++;
    end
  endtask

  int lat, bc, seen;

  initial begin
    reset  = 1'b1;
    start  = 1'b0;
    op     = 2'b00;
    mult1  = '0;
    mult2  = '0;
    start8 = 1'b0;
    op8    = 2'b00;
    a8     = '0;
    b8     = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);
    check("rst_divzero", div_zero, 0);
    check("rst8_busy", busy8, 0);
    reset = 1'b0;
    @(negedge clk);

    // MULTU 5*6
    launch(2'b00, 32'd5, 32'd6);
    check("multu_busy", busy, 1);
    wait_done(0, lat, bc);
    check("multu_lat", lat, 33);
    check("multu_busy_cycles", bc, 33);
    check("multu_busy_at_done", busy, 0);
    check("multu_hi", hi, 32'h0000_0000);
    check("multu_lo", lo, 32'h0000_001e);
    @(negedge clk);
    check("multu_done_single", done, 0);

    // MULT -3*7, then back-to-back MULT during the done cycle
    launch(2'b01, 32'hffff_fffd, 32'd7);
    wait_done(0, lat, bc);
    check("mult_lat", lat, 33);
    check("mult_hi", hi, 32'hffff_ffff);
    check("mult_lo", lo, 32'hffff_ffeb);
    launch(2'b01, 32'h8000_0000, 32'h8000_0000);
    check("b2b_done_low", done, 0);
    check("b2b_busy", busy, 1);
    check("b2b_hold_lo", lo, 32'hffff_ffeb);
    wait_done(0, lat, bc);
    check("b2b_lat", lat, 33);
    check("b2b_hi", hi, 32'h4000_0000);
    check("b2b_lo", lo, 32'h0000_0000);

    // DIV -7/2
    @(negedge clk);
    launch(2'b11, 32'hffff_fff9, 32'd2);
    wait_done(0, lat, bc);
    check("div_lo", lo, 32'hffff_fffd);
    check("div_hi", hi, 32'hffff_ffff);

    // DIVU 0xFFFFFFFF/0x10
    @(negedge clk);
    launch(2'b10, 32'hffff_ffff, 32'h10);
    wait_done(0, lat, bc);
    check("divu_lo", lo, 32'h0fff_ffff);
    check("divu_hi", hi, 32'h0000_000f);
    check("divu_divzero", div_zero, 0);

    // DIVU 9/0
    @(negedge clk);
    launch(2'b10, 32'd9, 32'd0);
    wait_done(0, lat, bc);
    check("dz_lat", lat, 1);
    check("dz_flag", div_zero, 1);
    check("dz_hi", hi, 32'h0000_0009);
    check("dz_lo", lo, 32'hffff_ffff);

    // MULTU 2*2 clears divZero
    @(negedge clk);
    launch(2'b00, 32'd2, 32'd2);
    check("hold_dz_during_run", div_zero, 1);
    wait_done(0, lat, bc);
    check("mul_after_dz_flag", div_zero, 0);
    check("mul_after_dz_lo", lo, 32'd4);

    // DIV most-negative / -1 with an ignored mid-run start
    @(negedge clk);
    launch(2'b11, 32'h8000_0000, 32'hffff_ffff);
    repeat (4) @(negedge clk);
    start = 1'b1;
    op    = 2'b10;
    mult1 = 32'd100;
    mult2 = 32'd7;
    @(negedge clk);
    start = 1'b0;
    check("midrun_hold_hi", hi, 32'h0);
    check("midrun_hold_lo", lo, 32'd4);
    wait_done(5, lat, bc);
    check("ovf_lat", lat, 33);
    check("ovf_lo", lo, 32'h8000_0000);
    check("ovf_hi", hi, 32'h0);
    check("ovf_divzero", div_zero, 0);
    @(negedge clk);
    check("midrun_not_queued", busy, 0);

    // DIV -5/0: hi keeps the signed dividend
    launch(2'b11, 32'hffff_fffb, 32'd0);
    wait_done(0, lat, bc);
    check("sdz_lat", lat, 1);
    check("sdz_hi", hi, 32'hffff_fffb);
    check("sdz_flag", div_zero, 1);

    // Reset raised at edge 10 of MULTU 10*20
    @(negedge clk);
    launch(2'b00, 32'd10, 32'd20);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_hi", hi, 0);
    check("abort_lo", lo, 0);
    check("abort_divzero", div_zero, 0);
    seen = 0;
    repeat (40) begin
      if (done) seen++;
      @(negedge clk);
    end
    check("abort_no_done", seen, 0);

    // WIDTH=8: MULT 0x80*0xFF
    start8 = 1'b1;
    op8    = 2'b01;
    a8     = 8'h80;
    b8     = 8'hff;
    @(negedge clk);
    start8 = 1'b0;
    a8     = 8'h11;
    b8     = 8'h22;
    lat = 0;
    while (!done8 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check("w8_lat", lat, 9);
    check("w8_hi", hi8, 8'h00);
    check("w8_lo", lo8, 8'h80);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mul_div_unit.md
# mul_div_unit

Parametrised sequential multiply/divide unit for the MIPS ALU. It is the successor of the single-mode 32-bit multiplier. It adds signed and unsigned multiply and divide, a full double-width result split into hi/lo (MULT/MULTU/DIV/DIVU semantics), a busy/done handshake, divide-by-zero detection and synchronous reset. One iteration runs per clock: shift-add for multiply, restoring for divide.

## Interface
- WIDTH, 32: operand width; hi and lo are each WIDTH bits; WIDTH >= 4.
- clockMul  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  request; sampled only in IDLE.
- op  in  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV; sampled with start.
- mult1  in  WIDTH  multiplicand / dividend; sampled with start.
- mult2  in  WIDTH  multiplier / divisor; sampled with start.
- busy  out  1  high from accept until the completion edge.
- done  out  1  one-cycle pulse; hi/lo valid and stable.
- hi  out  WIDTH  product upper half / remainder.
- lo  out  WIDTH  product lower half / quotient.
- divZero  out  1  last completed op was a divide with mult2 == 0.

## Operation
- Reset state (reset high at an edge): IDLE, busy=0, done=0, divZero=0, hi=0, lo=0, iteration counter=0.
- IDLE:
  - start=1: capture op and operands; for signed ops capture absolute values and the sign bits; go to RUN; busy=1.
  - DIV/DIVU with mult2==0: go directly to FIX instead of RUN.
- RUN: exactly WIDTH iterations, one per edge, then go to FIX.
  - Multiply: 2W-bit accumulator, conditional add of |B| then shift.
  - Divide: restoring divide of |A| by |B|, producing a W-bit quotient and a W-bit remainder.
- FIX: one edge. Apply signs, write hi/lo, set done=1 and busy=0, update divZero; go to IDLE.
- Width and sign rules:
  - MULTU: {hi,lo} = mult1*mult2 (unsigned, 2W bits).
  - MULT: two's-complement 2W-bit product; negate the magnitude if the operand signs differ.
  - DIVU: lo = quotient, hi = remainder (unsigned).
  - DIV: quotient truncates toward zero; remainder takes the sign of the dividend.
  - DIV of most-negative by -1: lo = most-negative, hi = 0, no flag.
- Divide by zero (DIV or DIVU): hi = mult1, lo = all ones, divZero = 1.
- divZero is cleared at every other completion.
- hi/lo change only at the FIX edge and hold otherwise, including across later starts until that op's FIX.
- start while busy or in FIX: ignored; operands are not re-sampled and no queueing occurs.
- Operand inputs may change freely after the accept edge.
- reset mid-operation: abort to IDLE at that edge. No done pulse. hi, lo and divZero are forced to 0.

## Timing
- Edge 0: start sampled in IDLE; busy=1 after this edge.
- Edges 1..WIDTH: iterations.
- Edge WIDTH+1: FIX. done=1 and busy=0 after this edge.
- Edge WIDTH+2: done returns to 0; a start held during the done cycle is accepted here.
- Throughput: one op per WIDTH+2 cycles.
- Divide by zero: accept at edge 0, FIX at edge 1. done is high for the cycle after edge 1; latency 2.
- done never coincides with busy=1.
- done is never high for two consecutive cycles.

## Test plan
- WIDTH=32, MULTU 5*6, start for one cycle: busy for 33 cycles; done after edge 33; hi=0x00000000, lo=0x0000001E.
- MULT -3*7, then a back-to-back start during the done cycle: first op gives hi=0xFFFFFFFF, lo=0xFFFFFFEB. Second op, MULT 0x80000000*0x80000000, gives hi=0x40000000, lo=0x00000000.
- DIV -7/2: lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 0xFFFFFFFF/0x10: lo=0x0FFFFFFF, hi=0x0000000F.
- DIVU 9/0: done after edge 1; divZero=1, hi=0x00000009, lo=0xFFFFFFFF. The next MULTU 2*2 gives divZero=0, lo=4.
- DIV 0x80000000/0xFFFFFFFF: lo=0x80000000, hi=0, divZero=0. A start pulsed mid-RUN with new operands is ignored and the result is unchanged.
- Reset raised at edge 10 of a MULTU 10*20: busy=0, done never pulses, hi=lo=0. With WIDTH=8, MULT 0x80*0xFF gives hi=0x00, lo=0x80, done after edge 9.
